// File: rtl/perf_mon.sv
// -----------------------------------------------------------------------------
// perf_mon -- performance monitor with one free-running cycle counter and
// NUM_EVT event counters, gated by an IDLE/RUN/FROZEN control FSM.
//
// Ports
//   i_clk       clock, all state updates on the rising edge
//   i_rstn      asynchronous active-low reset
//   i_start     begin / resume counting (IDLE or FROZEN -> RUN)
//   i_stop      end counting (RUN -> FROZEN)
//   i_clr       synchronous clear of counters, overflow flags and state
//   i_evt       per-channel event strobes, sampled every cycle
//   i_rd_req    readout request
//   i_rd_idx    readout index: 0 = cycle counter, k = event channel k-1
//   o_rd_vld    readout valid, one cycle after i_rd_req
//   o_rd_data   readout value (holds while o_rd_vld is low)
//   o_ovf       sticky overflow flags, bit 0 = cycle counter, bit k = channel k-1
//   o_state     00 IDLE, 01 RUN, 10 FROZEN
//   o_done      high while FROZEN
// -----------------------------------------------------------------------------
module perf_mon #(
    parameter int NUM_EVT = 4,
    parameter int CNT_W   = 32,
    parameter int SAT     = 0,
    localparam int IDX_W  = $clog2(NUM_EVT + 1)
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_clr,
    input  logic [NUM_EVT-1:0] i_evt,
    input  logic               i_rd_req,
    input  logic [IDX_W-1:0]   i_rd_idx,
    output logic               o_rd_vld,
    output logic [CNT_W-1:0]   o_rd_data,
    output logic [NUM_EVT:0]   o_ovf,
    output logic [1:0]         o_state,
    output logic               o_done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_FROZEN = 2'b10
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic               w_run;
    logic [NUM_EVT:0]   w_inc;
    logic [CNT_W-1:0]   w_cnt [NUM_EVT+1];
    logic [CNT_W-1:0]   w_rd_val;
    logic               r_rd_vld;
    logic [CNT_W-1:0]   r_rd_data;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                // start+stop together from IDLE jumps straight to FROZEN
                if (i_start && i_stop) begin
                    w_state_next = ST_FROZEN;
                end else if (i_start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_stop) begin
                    w_state_next = ST_FROZEN;
                end
            end
            ST_FROZEN: begin
                if (i_start && !i_stop) begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (i_clr) begin
            w_state_next = ST_IDLE;
        end
    end

    // Counting happens only while already in RUN, so the i_start cycle is
    // never counted but the i_stop cycle is. Clear overrides everything.
    assign w_run = (r_state == ST_RUN) && !i_clr;

    // ------------------------------------------------------------------
    // Counters: index 0 is the cycle counter, index k follows i_evt[k-1]
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi <= NUM_EVT; gi++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;
            logic             r_ovf;

            if (gi == 0) begin : g_cyc
                assign w_inc[gi] = w_run;
            end else begin : g_evt
                assign w_inc[gi] = w_run & i_evt[gi-1];
            end

            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    r_cnt <= '0;
                    r_ovf <= 1'b0;
                end else if (i_clr) begin
                    r_cnt <= '0;
                    r_ovf <= 1'b0;
                end else if (w_inc[gi]) begin
                    if (&r_cnt) begin
                        // increment from all-ones: flag it, then wrap or hold
                        r_ovf <= 1'b1;
                        r_cnt <= (SAT != 0) ? r_cnt : '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            end

            assign w_cnt[gi] = r_cnt;
            assign o_ovf[gi] = r_ovf;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Readout: registered, samples pre-increment values; indices beyond
    // NUM_EVT read as zero.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_val = '0;
        for (int k = 0; k <= NUM_EVT; k++) begin
            if (i_rd_idx == IDX_W'(k)) begin
                w_rd_val = w_cnt[k];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_rd_vld  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rd_vld <= i_rd_req;
            if (i_rd_req) begin
                r_rd_data <= w_rd_val;
            end
        end
    end

    assign o_rd_vld  = r_rd_vld;
    assign o_rd_data = r_rd_data;
    assign o_state   = r_state;
    assign o_done    = (r_state == ST_FROZEN);

endmodule

// File: doc/perf_mon.md
PERF_MON -- requirements
Module: perf_mon

Interface
REQ-001 Parameter NUM_EVT, default 4: number of event counter channels, range 1..15.
REQ-002 Parameter CNT_W, default 32: width of every counter, range 8..64.
REQ-003 Parameter SAT, default 0: overflow mode; 0 = wrap, 1 = saturate.
REQ-004 Local IDX_W = clog2(NUM_EVT+1); index 0 = cycle counter; index k (1..NUM_EVT) = event channel k-1.
REQ-005 One clock; reset is asynchronous and active-low; ports named i_clk and i_rstn.
REQ-006 i_clk  in  1  clock; all state updates on its rising edge.
REQ-007 i_rstn  in  1  asynchronous active-low reset.
REQ-008 i_start  in  1  begin counting (IDLE to RUN).
REQ-009 i_stop  in  1  end counting (RUN to FROZEN).
REQ-010 i_clr  in  1  synchronous clear of all counters, flags and state.
REQ-011 i_evt  in  NUM_EVT  per-channel event strobes (e.g. retired insn, branch, mispredict), sampled each cycle.
REQ-012 i_rd_req  in  1  readout request.
REQ-013 i_rd_idx  in  IDX_W  readout counter index.
REQ-014 o_rd_vld  out  1  readout data valid.
REQ-015 o_rd_data  out  CNT_W  readout value.
REQ-016 o_ovf  out  NUM_EVT+1  sticky overflow flags; bit 0 = cycle counter, bit k = channel k-1.
REQ-017 o_state  out  2  state encoding: 00 IDLE, 01 RUN, 10 FROZEN.
REQ-018 o_done  out  1  high while state is FROZEN.

Function
REQ-019 Three-state FSM: IDLE -(i_start)-> RUN -(i_stop)-> FROZEN -(i_start)-> RUN. FROZEN to RUN resumes from held values without clearing.
REQ-020 In RUN, the cycle counter increments by 1 every cycle, including the cycle in which i_stop is sampled.
REQ-021 In RUN, counter k increments by 1 in each cycle with i_evt[k-1]=1, including the i_stop cycle.
REQ-022 In IDLE and FROZEN, no counter changes.
REQ-023 The cycle in which i_start is sampled is not counted; counting begins the following cycle.
REQ-024 i_start and i_stop sampled together: from IDLE go to FROZEN with no counting; in RUN count that cycle, then go to FROZEN; in FROZEN stay in FROZEN.
REQ-025 i_clr has highest priority: next cycle all counters are 0, o_ovf is 0 and the state is IDLE; i_start, i_stop and events in that cycle are ignored.
REQ-026 Wrap mode (SAT=0): increment from all-ones gives 0 and sets the matching o_ovf bit.
REQ-027 Saturate mode (SAT=1): a counter at all-ones holds; an increment attempt sets the matching o_ovf bit.
REQ-028 o_ovf bits stay set until i_clr or reset.
REQ-029 Readout latency is 1 cycle: o_rd_vld=1 and o_rd_data=counter[i_rd_idx] in the cycle after i_rd_req; otherwise o_rd_vld=0.
REQ-030 Readout returns the counter value before any increment in the request cycle.
REQ-031 i_rd_idx > NUM_EVT returns o_rd_data=0 with o_rd_vld=1.
REQ-032 Back-to-back requests are accepted every cycle; readout works in all states.
REQ-033 o_rd_data holds its last value while o_rd_vld=0.
REQ-034 A request in the same cycle as i_clr returns the pre-clear value.

Reset
REQ-035 While i_rstn=0: all counters 0, o_ovf=0, o_state=00, o_done=0, o_rd_vld=0, o_rd_data=0.
REQ-036 Reset asserted mid-RUN aborts immediately with no counts retained; after release the block stays in IDLE until i_start.

Verification
REQ-037 NUM_EVT=4, CNT_W=32: i_start, 10 RUN cycles with i_evt=0001 every cycle and 0100 on 3 of them, then i_stop -> idx0=11, idx1=11, idx3=3, idx2=0, o_done=1.
REQ-038 CNT_W=8, SAT=0: 257 RUN cycles -> idx0=1, o_ovf[0]=1; with SAT=1 -> idx0=255, o_ovf[0]=1.
REQ-039 FROZEN, 5 further event pulses, then i_start and 2 RUN cycles -> event counts unchanged during FROZEN; cycle counter grows by 2.
REQ-040 i_clr asserted in the same cycle as i_start and i_evt=1111 -> next cycle state IDLE, all counters 0, o_ovf=0.
REQ-041 i_rd_req with idx 0..5 on consecutive cycles -> o_rd_vld high for 6 cycles, 1 cycle late; idx5 returns 0.
REQ-042 Reset pulse mid-RUN with counters nonzero -> all outputs 0 asynchronously; IDLE after release.
